// File: rtl/fetch_queue.sv
// Fetch queue between IF and decode: circular FIFO of instruction,
// PC and prediction metadata, with single-cycle flush.
module fetch_queue #(
  parameter int INSTR_WIDTH = 32,
  parameter int ADDR_WIDTH  = 32,
  parameter int DEPTH       = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    enq_valid_i,
  output logic                    enq_ready_o,
  input  logic [INSTR_WIDTH-1:0]  enq_instr_i,
  input  logic [ADDR_WIDTH-1:0]   enq_pc_i,
  input  logic                    enq_hit_i,
  input  logic                    enq_pred_i,
  input  logic [ADDR_WIDTH-1:0]   enq_trgt_i,
  output logic                    deq_valid_o,
  input  logic                    deq_ready_i,
  output logic [INSTR_WIDTH-1:0]  deq_instr_o,
  output logic [ADDR_WIDTH-1:0]   deq_pc_o,
  output logic                    deq_hit_o,
  output logic                    deq_pred_o,
  output logic [ADDR_WIDTH-1:0]   deq_trgt_o,
  input  logic                    flush_i,
  output logic [$clog2(DEPTH):0]  count_o
);

  localparam int IW = $clog2(DEPTH);
  localparam int PW = IW + 1;

  typedef struct packed {
    logic [INSTR_WIDTH-1:0] instr;
    logic [ADDR_WIDTH-1:0]  pc;
    logic                   hit;
    logic                   pred;
    logic [ADDR_WIDTH-1:0]  trgt;
  } entry_t;

  entry_t          mem_q [DEPTH];
  entry_t          wr_ent;
  entry_t          rd_ent;
  logic [PW-1:0]   wr_q, wr_d;
  logic [PW-1:0]   rd_q, rd_d;
  logic            full, empty;
  logic            enq_fire, deq_fire;

  assign empty = (wr_q == rd_q);
  assign full  = (wr_q[IW-1:0] == rd_q[IW-1:0]) &&
                 (wr_q[IW] != rd_q[IW]);

  assign enq_ready_o = !full;
  assign deq_valid_o = !empty;
  assign count_o     = wr_q - rd_q;

  assign enq_fire = enq_valid_i && !full;
  assign deq_fire = deq_ready_i && !empty;

  assign wr_ent.instr = enq_instr_i;
  assign wr_ent.pc    = enq_pc_i;
  assign wr_ent.hit   = enq_hit_i;
  assign wr_ent.pred  = enq_pred_i;
  assign wr_ent.trgt  = enq_trgt_i;

  assign rd_ent      = mem_q[rd_q[IW-1:0]];
  assign deq_instr_o = rd_ent.instr;
  assign deq_pc_o    = rd_ent.pc;
  assign deq_hit_o   = rd_ent.hit;
  assign deq_pred_o  = rd_ent.pred;
  assign deq_trgt_o  = rd_ent.trgt;

  // Flush wins over any enqueue/dequeue in the same cycle.
  always_comb begin
    wr_d = wr_q;
    rd_d = rd_q;
    if (flush_i) begin
      wr_d = '0;
      rd_d = '0;
    end else begin
      if (enq_fire) wr_d = wr_q + PW'(1);
      if (deq_fire) rd_d = rd_q + PW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (enq_fire && !flush_i) begin
      mem_q[wr_q[IW-1:0]] <= wr_ent;
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue using a queue-based scoreboard.
module tb_fetch_queue;

  localparam int DEPTH = 4;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        hit;
    logic        pred;
    logic [31:0] trgt;
  } entry_t;

  logic        clk = 0;
  logic        rst = 1;
  logic        enq_valid_i = 0;
  logic        enq_ready_o;
  logic [31:0] enq_instr_i = 0;
  logic [31:0] enq_pc_i = 0;
  logic        enq_hit_i = 0;
  logic        enq_pred_i = 0;
  logic [31:0] enq_trgt_i = 0;
  logic        deq_valid_o;
  logic        deq_ready_i = 0;
  logic [31:0] deq_instr_o;
  logic [31:0] deq_pc_o;
  logic        deq_hit_o;
  logic        deq_pred_o;
  logic [31:0] deq_trgt_o;
  logic        flush_i = 0;
  logic [2:0]  count_o;

  entry_t obs;
  entry_t sb[$];
  int     tests = 0;
  int     fails = 0;

  assign obs = {deq_instr_o, deq_pc_o, deq_hit_o,
                deq_pred_o, deq_trgt_o};

  always #5 clk = ~clk;

  fetch_queue #(.INSTR_WIDTH(32), .ADDR_WIDTH(32),
                .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .enq_valid_i(enq_valid_i), .enq_ready_o(enq_ready_o),
    .enq_instr_i(enq_instr_i), .enq_pc_i(enq_pc_i),
    .enq_hit_i(enq_hit_i), .enq_pred_i(enq_pred_i),
    .enq_trgt_i(enq_trgt_i),
    .deq_valid_o(deq_valid_o), .deq_ready_i(deq_ready_i),
    .deq_instr_o(deq_instr_o), .deq_pc_o(deq_pc_o),
    .deq_hit_o(deq_hit_o), .deq_pred_o(deq_pred_o),
    .deq_trgt_o(deq_trgt_o),
    .flush_i(flush_i), .count_o(count_o)
  );

  function automatic entry_t mk(input logic [31:0] pc);
    entry_t e;
    e.instr = {pc[15:0], 16'h0013} ^ 32'h5A000000;
    e.pc    = pc;
    e.hit   = pc[2];
    e.pred  = pc[3];
    e.trgt  = pc + 32'h0000_0040;
    return e;
  endfunction

  // Drive one cycle starting at a negedge; model updates at the posedge.
  task automatic drive(input bit en, input bit dr, input bit fl,
                       input entry_t e);
    bit was_full;
    enq_valid_i = en;
    deq_ready_i = dr;
    flush_i     = fl;
    enq_instr_i = e.instr;
    enq_pc_i    = e.pc;
    enq_hit_i   = e.hit;
    enq_pred_i  = e.pred;
    enq_trgt_i  = e.trgt;
    @(posedge clk);
    if (fl) begin
      sb.delete();
    end else begin
      was_full = (sb.size() == DEPTH);
      if (dr && sb.size() > 0) void'(sb.pop_front());
      if (en && !was_full) sb.push_back(e);
    end
    @(negedge clk);
    enq_valid_i = 0;
    deq_ready_i = 0;
    flush_i     = 0;
  endtask

  task automatic test_reset();
    #3;
    tests++;
    if (deq_valid_o !== 1'b0 || enq_ready_o !== 1'b1 ||
        count_o !== 3'd0) begin
      fails++;
      $display("FAIL reset_flags v=%b r=%b c=%0d exp v=0 r=1 c=0",
               deq_valid_o, enq_ready_o, count_o);
    end
    tests++;
    if (obs !== '0) begin
      fails++;
      $display("FAIL reset_fields got=%h exp=0", obs);
    end
    @(negedge clk);
    rst = 0;
  endtask

  task automatic test_fill();
    for (int i = 0; i < 4; i++)
      drive(1, 0, 0, mk(32'h100 + 32'(4 * i)));
    tests++;
    if (enq_ready_o !== 1'b0 || count_o !== 3'(sb.size())) begin
      fails++;
      $display("FAIL fill r=%b c=%0d exp r=0 c=%0d",
               enq_ready_o, count_o, sb.size());
    end
    drive(1, 0, 0, mk(32'h110));
    tests++;
    if (count_o !== 3'(sb.size()) || count_o !== 3'd4) begin
      fails++;
      $display("FAIL fill_refuse c=%0d exp=%0d", count_o, sb.size());
    end
  endtask

  task automatic test_drain();
    for (int i = 0; i < 4; i++) begin
      tests++;
      if (deq_valid_o !== 1'b1 || obs !== sb[0]) begin
        fails++;
        $display("FAIL drain_head%0d v=%b got=%h exp=%h",
                 i, deq_valid_o, obs, sb[0]);
      end
      drive(0, 1, 0, '0);
    end
    tests++;
    if (deq_valid_o !== 1'b0 || count_o !== 3'd0 || sb.size() != 0) begin
      fails++;
      $display("FAIL drain_empty v=%b c=%0d exp v=0 c=0",
               deq_valid_o, count_o);
    end
  endtask

  task automatic test_back_to_back();
    drive(1, 0, 0, mk(32'h300));
    drive(1, 0, 0, mk(32'h304));
    for (int i = 0; i < 10; i++) begin
      tests++;
      if (deq_valid_o !== 1'b1 || obs !== sb[0]) begin
        fails++;
        $display("FAIL b2b_head%0d v=%b got=%h exp=%h",
                 i, deq_valid_o, obs, sb[0]);
      end
      drive(1, 1, 0, mk(32'h308 + 32'(4 * i)));
      tests++;
      if (count_o !== 3'd2 || count_o !== 3'(sb.size())) begin
        fails++;
        $display("FAIL b2b_count%0d c=%0d exp=2", i, count_o);
      end
    end
    for (int i = 0; i < 2; i++) begin
      tests++;
      if (obs !== sb[0]) begin
        fails++;
        $display("FAIL b2b_tail%0d got=%h exp=%h", i, obs, sb[0]);
      end
      drive(0, 1, 0, '0);
    end
  endtask

  task automatic test_full_deq();
    for (int i = 0; i < 4; i++)
      drive(1, 0, 0, mk(32'h400 + 32'(4 * i)));
    tests++;
    if (obs !== sb[0] || enq_ready_o !== 1'b0) begin
      fails++;
      $display("FAIL fulldeq_head r=%b got=%h exp=%h",
               enq_ready_o, obs, sb[0]);
    end
    drive(1, 1, 0, mk(32'h4F0));
    tests++;
    if (count_o !== 3'd3 || enq_ready_o !== 1'b1 ||
        obs !== sb[0]) begin
      fails++;
      $display("FAIL fulldeq c=%0d r=%b got=%h exp c=3 r=1 %h",
               count_o, enq_ready_o, obs, sb[0]);
    end
  endtask

  task automatic test_flush();
    drive(1, 1, 1, mk(32'h500));
    tests++;
    if (count_o !== 3'd0 || deq_valid_o !== 1'b0 ||
        enq_ready_o !== 1'b1) begin
      fails++;
      $display("FAIL flush c=%0d v=%b r=%b exp c=0 v=0 r=1",
               count_o, deq_valid_o, enq_ready_o);
    end
    drive(1, 0, 0, mk(32'h200));
    tests++;
    if (deq_valid_o !== 1'b1 || obs !== sb[0] ||
        deq_pc_o !== 32'h200) begin
      fails++;
      $display("FAIL flush_next v=%b got=%h exp=%h",
               deq_valid_o, obs, sb[0]);
    end
    drive(0, 1, 0, '0);
    tests++;
    if (deq_valid_o !== 1'b0 || count_o !== 3'd0) begin
      fails++;
      $display("FAIL flush_drain v=%b c=%0d exp v=0 c=0",
               deq_valid_o, count_o);
    end
  endtask

  task automatic test_async_reset();
    drive(1, 0, 0, mk(32'h600));
    drive(1, 0, 0, mk(32'h604));
    tests++;
    if (count_o !== 3'd2) begin
      fails++;
      $display("FAIL arst_pre c=%0d exp=2", count_o);
    end
    #2 rst = 1;
    #1;
    sb.delete();
    tests++;
    if (deq_valid_o !== 1'b0 || count_o !== 3'd0 ||
        enq_ready_o !== 1'b1 || obs !== '0) begin
      fails++;
      $display("FAIL arst v=%b c=%0d r=%b f=%h exp v=0 c=0 r=1 f=0",
               deq_valid_o, count_o, enq_ready_o, obs);
    end
    @(negedge clk);
    rst = 0;
    drive(1, 0, 0, mk(32'h700));
    tests++;
    if (deq_valid_o !== 1'b1 || obs !== sb[0]) begin
      fails++;
      $display("FAIL arst_after v=%b got=%h exp=%h",
               deq_valid_o, obs, sb[0]);
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_drain();
    test_back_to_back();
    test_full_deq();
    test_flush();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fetch_queue.md
# fetch_queue

Instruction fetch queue between the IF stage and decode. It buffers fetched instructions together with their PC and branch-prediction metadata (predictor hit and direction, BTB target) in a circular FIFO. This decouples fetch from decode stalls. A flush from the branch-resolution logic discards every buffered entry in a single cycle.

## Interface
- INSTR_WIDTH, 32, instruction word width
- ADDR_WIDTH, 32, PC and target width
- DEPTH, 4, number of entries; must be a power of two, ≥ 2
- clk  in  1  clock; all state updates on posedge
- rst  in  1  asynchronous, active-high reset
- enq_valid_i  in  1  fetch presents an entry
- enq_ready_o  out  1  queue can accept an entry (= not full)
- enq_instr_i  in  INSTR_WIDTH  instruction word
- enq_pc_i  in  ADDR_WIDTH  PC of the instruction
- enq_hit_i  in  1  predictor/BTB hit for this PC
- enq_pred_i  in  1  predicted taken
- enq_trgt_i  in  ADDR_WIDTH  predicted target
- deq_valid_o  out  1  head entry valid (= not empty)
- deq_ready_i  in  1  decode accepts head
- deq_instr_o, deq_pc_o, deq_hit_o, deq_pred_o, deq_trgt_o  out  as enq  head entry fields
- flush_i  in  1  discard all entries
- count_o  out  $clog2(DEPTH)+1  current occupancy

## Operation
- Storage: DEPTH-entry array. Write pointer and read pointer are each $clog2(DEPTH)+1 bits; the MSB is the wrap bit.
- Empty when the pointers are equal. Full when the low bits are equal and the wrap bits differ. count_o = wr_ptr − rd_ptr, modulo 2^(ptr width).
- Enqueue fires when enq_valid_i && enq_ready_o. The entry is written at wr_ptr, and wr_ptr increments.
- Dequeue fires when deq_valid_o && deq_ready_i. rd_ptr increments.
- Enqueue and dequeue may fire in the same cycle. count is unchanged and both pointers advance.
- enq_ready_o = !full. It is combinational from state only, with no dependence on deq_ready_i. When full, no enqueue is accepted even if a dequeue fires that cycle.
- deq_valid_o = !empty. There is no combinational bypass: an entry enqueued into an empty queue appears on deq_* in the next cycle.
- deq_* fields are driven directly from the slot at rd_ptr. When empty they carry the stale slot contents and have no meaning.
- Flush: when flush_i is high at a posedge, both pointers are set to 0. Any enqueue or dequeue that cycle is ignored. Flush has priority over all other events. Storage contents are not cleared.
- enq_pred_i and enq_trgt_i are stored exactly as given, even when enq_hit_i = 0. The queue interprets no field.
- Pointer wrap: low bits roll from DEPTH−1 to 0 and the wrap bit toggles. No special case is needed.
- Protocol violation handling: enq_valid_i while full is simply not accepted. The producer must hold its entry until it sees enq_ready_o.

## Timing
- Reset (asynchronous assert, takes effect immediately):
  - pointers = 0 and all storage entries = 0;
  - deq_valid_o = 0, enq_ready_o = 1, count_o = 0;
  - deq_instr_o, deq_pc_o, deq_hit_o, deq_pred_o, deq_trgt_o = 0.
- Reset asserted mid-operation discards all entries immediately, regardless of clk.
- Deassertion is sampled at the next posedge. The block is ready to accept an enqueue in that same cycle.
- Latency from enqueue into an empty queue to deq_valid_o = 1 cycle.
- Throughput: 1 enqueue and 1 dequeue per cycle sustained, while not full.
- Flush latency: the queue is empty starting in the cycle after the flush posedge. enq_ready_o = 1 and deq_valid_o = 0 in that cycle.
- All outputs are functions of registered state only, with no input→output combinational paths. This removes timing loops with fetch and decode.

## Test plan
- Reset, then fill: after rst, enqueue 4 entries with PC 0x100, 0x104, 0x108, 0x10C.
  - Required: enq_ready_o = 0 after the 4th, count_o = 4.
  - A 5th enqueue (PC 0x110) is refused, and count_o stays 4.
- Drain in order: from the full state, hold deq_ready_i = 1 for 4 cycles.
  - Required: PCs 0x100 through 0x10C appear in order, with their instr/hit/pred/trgt fields intact.
  - Then deq_valid_o = 0 and count_o = 0.
- Simultaneous enqueue and dequeue at count 2, 10 consecutive cycles.
  - Required: count_o stays 2 and the output order matches the input order.
  - Pointers wrap at least twice without corruption.
- Full with a dequeue: at count 4, assert enq_valid_i and deq_ready_i together.
  - Required: the dequeue fires, the enqueue is refused, and count_o becomes 3.
- Flush priority: at count 3, assert flush_i together with enq_valid_i and deq_ready_i.
  - Required next cycle: count_o = 0, deq_valid_o = 0, and the flushed enqueue entry is never output.
  - A following enqueue of PC 0x200 appears at the head one cycle later.
- Asynchronous reset mid-stream: assert rst between clock edges while count = 2.
  - Required: deq_valid_o = 0, count_o = 0, and enq_ready_o = 1 immediately, before the next posedge.
